// File: rtl/display_scan_ctrl_if.sv
// Bus between application logic and the display scan controller.
// Carries display value, load strobe, digit mask and scan outputs.
interface display_scan_ctrl_if #(
  parameter int N_DIGITS = 4
);
  logic [4*N_DIGITS-1:0] i_Valor;
  logic                  i_Cargar;
  logic [N_DIGITS-1:0]   i_Hab_Dig;
  logic [3:0]            o_Nibble;
  logic [N_DIGITS-1:0]   o_Digitos;
  logic                  o_Pendiente;
  logic                  o_Fin_Cuadro;

  modport master (
    output i_Valor, i_Cargar, i_Hab_Dig,
    input  o_Nibble, o_Digitos, o_Pendiente, o_Fin_Cuadro
  );

  modport slave (
    input  i_Valor, i_Cargar, i_Hab_Dig,
    output o_Nibble, o_Digitos, o_Pendiente, o_Fin_Cuadro
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with blanking gaps
// and a frame-synchronous double-buffered display value.
module display_scan_ctrl #(
  parameter int N_DIGITS     = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                i_Clk,
  input  logic                i_Rst,
  display_scan_ctrl_if.slave  bus
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(N_DIGITS);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SHOW_LAST =
    CW'(REFRESH_DIV - BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic [IW-1:0]         r_idx;
  logic [4*N_DIGITS-1:0] r_active;
  logic [4*N_DIGITS-1:0] r_pending;

  logic                  w_slot_end;
  logic                  w_boundary;
  logic [IW-1:0]         w_idx_nxt;
  logic [4*N_DIGITS-1:0] w_active_nxt;
  logic [3:0]            w_nib_nxt;
  logic [N_DIGITS-1:0]   w_dig_on;

  assign w_slot_end = (r_state == ST_SHOW) && (r_cnt == SHOW_LAST);
  assign w_boundary = w_slot_end && (r_idx == IDX_LAST);
  assign w_idx_nxt  = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;

  // newest value wins when a load collides with the frame boundary
  always_comb begin
    w_active_nxt = r_active;
    if (w_boundary) begin
      if (bus.i_Cargar)
        w_active_nxt = bus.i_Valor;
      else if (bus.o_Pendiente)
        w_active_nxt = r_pending;
    end
  end

  always_comb begin
    w_nib_nxt = '0;
    w_dig_on  = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (w_idx_nxt == IW'(k))
        w_nib_nxt = w_active_nxt[4*k +: 4];
      w_dig_on[k] = (r_idx == IW'(k)) & bus.i_Hab_Dig[k];
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_state          <= ST_BLANK;
      r_cnt            <= '0;
      r_idx            <= '0;
      r_active         <= '0;
      r_pending        <= '0;
      bus.o_Nibble     <= '0;
      bus.o_Digitos    <= '0;
      bus.o_Pendiente  <= 1'b0;
      bus.o_Fin_Cuadro <= 1'b0;
    end else begin
      bus.o_Fin_Cuadro <= 1'b0;

      if (w_boundary) begin
        r_active        <= w_active_nxt;
        bus.o_Pendiente <= 1'b0;
      end else if (bus.i_Cargar) begin
        r_pending       <= bus.i_Valor;
        bus.o_Pendiente <= 1'b1;
      end

      unique case (r_state)
        ST_BLANK: begin
          bus.o_Digitos <= '0;
          if (r_cnt == BLANK_LAST) begin
            r_state       <= ST_SHOW;
            r_cnt         <= '0;
            bus.o_Digitos <= w_dig_on;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_SHOW: begin
          if (w_slot_end) begin
            r_state          <= ST_BLANK;
            r_cnt            <= '0;
            r_idx            <= w_idx_nxt;
            bus.o_Digitos    <= '0;
            bus.o_Nibble     <= w_nib_nxt;
            bus.o_Fin_Cuadro <= w_boundary;
          end else begin
            r_cnt         <= r_cnt + 1'b1;
            bus.o_Digitos <= w_dig_on;
          end
        end
        default: begin
          r_state <= ST_BLANK;
          r_cnt   <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with N=4, DIV=8, BLANK=2.
// Positions t are cycles after a frame boundary observation.
module tb_display_scan_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;

  display_scan_ctrl_if #(.N_DIGITS(4)) bus ();

  display_scan_ctrl #(
    .N_DIGITS(4),
    .REFRESH_DIV(8),
    .BLANK_CYCLES(2)
  ) dut (
    .i_Clk(clk),
    .i_Rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_frame(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      tick();
      if (bus.o_Fin_Cuadro === 1'b1) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s frame_timeout got=0 want=1", tag);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_Valor = '0;
    bus.i_Cargar = 1'b0;
    bus.i_Hab_Dig = 4'b1111;
    ticks(3);
    total++;
    if ({bus.o_Nibble, bus.o_Digitos, bus.o_Pendiente,
         bus.o_Fin_Cuadro} !== 10'd0) begin
      bad++;
      $display("FAIL reset_outs got=%b%b%b%b want=0", bus.o_Nibble,
               bus.o_Digitos, bus.o_Pendiente, bus.o_Fin_Cuadro);
    end
    rst = 1'b0;
    tick();
    total++;
    if (bus.o_Digitos !== 4'b0000) begin
      bad++;
      $display("FAIL rel_blank got=%b want=0000", bus.o_Digitos);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if (bus.o_Digitos !== 4'b0001) begin
        bad++;
        $display("FAIL rel_show%0d got=%b want=0001", i, bus.o_Digitos);
      end
    end
    tick();
    total++;
    if (bus.o_Digitos !== 4'b0000) begin
      bad++;
      $display("FAIL rel_end got=%b want=0000", bus.o_Digitos);
    end
  endtask

  task automatic test_scan_order();
    logic [15:0] act = 16'h4321;
    bus.i_Hab_Dig = 4'b1111;
    bus.i_Valor = act;
    bus.i_Cargar = 1'b1;
    tick();
    bus.i_Cargar = 1'b0;
    total++;
    if (bus.o_Pendiente !== 1'b1) begin
      bad++;
      $display("FAIL scan_pend got=%b want=1", bus.o_Pendiente);
    end
    wait_frame("scan");
    total++;
    if (bus.o_Nibble !== 4'h1 || bus.o_Pendiente !== 1'b0) begin
      bad++;
      $display("FAIL scan_apply nib=%h pend=%b want 1/0",
               bus.o_Nibble, bus.o_Pendiente);
    end
    for (int t = 1; t < 32; t++) begin
      int s = t / 8;
      logic [3:0] ed;
      tick();
      ed = (t % 8 >= 2) ? 4'(1 << s) : 4'b0000;
      total++;
      if (bus.o_Digitos !== ed || bus.o_Nibble !== act[s*4 +: 4]
          || bus.o_Fin_Cuadro !== 1'b0) begin
        bad++;
        $display("FAIL scan_t%0d dig=%b nib=%h fin=%b want %b/%h/0", t,
                 bus.o_Digitos, bus.o_Nibble, bus.o_Fin_Cuadro, ed,
                 act[s*4 +: 4]);
      end
    end
    tick();
    total++;
    if (bus.o_Fin_Cuadro !== 1'b1) begin
      bad++;
      $display("FAIL scan_period fin=%b want=1", bus.o_Fin_Cuadro);
    end
  endtask

  task automatic test_double_buffer();
    logic [15:0] old = 16'h4321;
    ticks(12);
    bus.i_Valor = 16'hABCD;
    bus.i_Cargar = 1'b1;
    tick();
    bus.i_Cargar = 1'b0;
    total++;
    if (bus.o_Pendiente !== 1'b1 || bus.o_Nibble !== 4'h2) begin
      bad++;
      $display("FAIL dbuf_load pend=%b nib=%h want 1/2",
               bus.o_Pendiente, bus.o_Nibble);
    end
    for (int t = 14; t < 32; t++) begin
      int s = t / 8;
      tick();
      total++;
      if (bus.o_Nibble !== old[s*4 +: 4] || bus.o_Pendiente !== 1'b1) begin
        bad++;
        $display("FAIL dbuf_old_t%0d nib=%h pend=%b want %h/1", t,
                 bus.o_Nibble, bus.o_Pendiente, old[s*4 +: 4]);
      end
    end
    tick();
    total++;
    if (bus.o_Fin_Cuadro !== 1'b1 || bus.o_Pendiente !== 1'b0
        || bus.o_Nibble !== 4'hD) begin
      bad++;
      $display("FAIL dbuf_apply fin=%b pend=%b nib=%h want 1/0/d",
               bus.o_Fin_Cuadro, bus.o_Pendiente, bus.o_Nibble);
    end
    ticks(8);
    total++;
    if (bus.o_Nibble !== 4'hC) begin
      bad++;
      $display("FAIL dbuf_dig1 nib=%h want=c", bus.o_Nibble);
    end
  endtask

  task automatic test_overwrite();
    bus.i_Valor = 16'h1111;
    bus.i_Cargar = 1'b1;
    tick();
    bus.i_Cargar = 1'b0;
    ticks(11);
    bus.i_Valor = 16'h2222;
    bus.i_Cargar = 1'b1;
    tick();
    bus.i_Cargar = 1'b0;
    total++;
    if (bus.o_Pendiente !== 1'b1) begin
      bad++;
      $display("FAIL ovw_pend got=%b want=1", bus.o_Pendiente);
    end
    ticks(11);
    total++;
    if (bus.o_Fin_Cuadro !== 1'b1 || bus.o_Nibble !== 4'h2
        || bus.o_Pendiente !== 1'b0) begin
      bad++;
      $display("FAIL ovw_apply fin=%b nib=%h pend=%b want 1/2/0",
               bus.o_Fin_Cuadro, bus.o_Nibble, bus.o_Pendiente);
    end
    ticks(31);
    bus.i_Valor = 16'h3333;
    bus.i_Cargar = 1'b1;
    tick();
    bus.i_Cargar = 1'b0;
    total++;
    if (bus.o_Fin_Cuadro !== 1'b1 || bus.o_Nibble !== 4'h3
        || bus.o_Pendiente !== 1'b0) begin
      bad++;
      $display("FAIL collide fin=%b nib=%h pend=%b want 1/3/0",
               bus.o_Fin_Cuadro, bus.o_Nibble, bus.o_Pendiente);
    end
    tick();
    total++;
    if (bus.o_Pendiente !== 1'b0) begin
      bad++;
      $display("FAIL collide_pend got=%b want=0", bus.o_Pendiente);
    end
  endtask

  task automatic test_mask();
    logic [3:0] hab = 4'b0101;
    bus.i_Hab_Dig = hab;
    wait_frame("mask");
    for (int t = 1; t < 32; t++) begin
      int s = t / 8;
      logic [3:0] ed;
      tick();
      ed = (t % 8 >= 2 && hab[s]) ? 4'(1 << s) : 4'b0000;
      total++;
      if (bus.o_Digitos !== ed || bus.o_Fin_Cuadro !== 1'b0) begin
        bad++;
        $display("FAIL mask_t%0d dig=%b fin=%b want %b/0", t,
                 bus.o_Digitos, bus.o_Fin_Cuadro, ed);
      end
    end
    tick();
    total++;
    if (bus.o_Fin_Cuadro !== 1'b1) begin
      bad++;
      $display("FAIL mask_period fin=%b want=1", bus.o_Fin_Cuadro);
    end
    bus.i_Hab_Dig = 4'b1111;
  endtask

  task automatic test_reset_mid();
    bus.i_Valor = 16'h5555;
    bus.i_Cargar = 1'b1;
    tick();
    bus.i_Cargar = 1'b0;
    ticks(17);
    total++;
    if (bus.o_Digitos !== 4'b0100 || bus.o_Pendiente !== 1'b1) begin
      bad++;
      $display("FAIL rmid_pre dig=%b pend=%b want 0100/1",
               bus.o_Digitos, bus.o_Pendiente);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (bus.o_Digitos !== 4'b0000 || bus.o_Pendiente !== 1'b0
        || bus.o_Nibble !== 4'h0) begin
      bad++;
      $display("FAIL rmid_rst dig=%b pend=%b nib=%h want 0000/0/0",
               bus.o_Digitos, bus.o_Pendiente, bus.o_Nibble);
    end
    tick();
    total++;
    if (bus.o_Digitos !== 4'b0000) begin
      bad++;
      $display("FAIL rmid_blank dig=%b want=0000", bus.o_Digitos);
    end
    tick();
    total++;
    if (bus.o_Digitos !== 4'b0001 || bus.o_Nibble !== 4'h0) begin
      bad++;
      $display("FAIL rmid_restart dig=%b nib=%h want 0001/0",
               bus.o_Digitos, bus.o_Nibble);
    end
    wait_frame("rmid");
    total++;
    if (bus.o_Nibble !== 4'h0 || bus.o_Pendiente !== 1'b0) begin
      bad++;
      $display("FAIL rmid_discard nib=%h pend=%b want 0/0",
               bus.o_Nibble, bus.o_Pendiente);
    end
  endtask

  initial begin
    test_reset();
    test_scan_order();
    test_double_buffer();
    test_overwrite();
    test_mask();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
